// File: rtl/sonar_rx_parser.sv
// sonar_rx_parser
// Decodes the sonar's 8-character ASCII report "aaa,ddd#" coming from a UART
// receiver. Angle and distance are published as 3-digit BCD together with a
// one-cycle pronto pulse. Malformed frames raise a one-cycle erro pulse, and
// the parser then resynchronises on the next '#'.
//
//   state          | code | meaning
//   ---------------+------+------------------------------------------
//   INICIAL        |  0   | waiting for angle hundreds digit
//   ANG_DEZ        |  1   | waiting for angle tens digit
//   ANG_UNI        |  2   | waiting for angle units digit
//   ESPERA_VIRGULA |  3   | waiting for ','
//   MED_CEN        |  4   | waiting for distance hundreds digit
//   MED_DEZ        |  5   | waiting for distance tens digit
//   MED_UNI        |  6   | waiting for distance units digit
//   ESPERA_HASH    |  7   | waiting for '#' terminator
//   DESCARTA       |  8   | dropping bytes until '#' (resync)
module sonar_rx_parser #(
    parameter int DATA_BITS = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ligar,
    input  logic [DATA_BITS-1:0] dado_recebido,
    input  logic                 pronto_rx,
    output logic [11:0]          angulo,
    output logic [11:0]          distancia,
    output logic                 pronto,
    output logic                 erro,
    output logic [3:0]           db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        ANG_DEZ        = 4'd1,
        ANG_UNI        = 4'd2,
        ESPERA_VIRGULA = 4'd3,
        MED_CEN        = 4'd4,
        MED_DEZ        = 4'd5,
        MED_UNI        = 4'd6,
        ESPERA_HASH    = 4'd7,
        DESCARTA       = 4'd8
    } state_t;

    localparam logic [DATA_BITS-1:0] CH_ZERO    = DATA_BITS'('h30);
    localparam logic [DATA_BITS-1:0] CH_NINE    = DATA_BITS'('h39);
    localparam logic [DATA_BITS-1:0] CH_VIRGULA = DATA_BITS'('h2C);
    localparam logic [DATA_BITS-1:0] CH_HASH    = DATA_BITS'('h23);

    state_t      state, state_next;
    logic [11:0] sh_ang, sh_ang_next;
    logic [11:0] sh_dist, sh_dist_next;
    logic        pronto_next;
    logic        erro_next;

    logic        is_digit;
    logic        is_virgula;
    logic        is_hash;
    logic [3:0]  digito;

    assign is_digit   = (dado_recebido >= CH_ZERO) && (dado_recebido <= CH_NINE);
    assign is_virgula = (dado_recebido == CH_VIRGULA);
    assign is_hash    = (dado_recebido == CH_HASH);
    assign digito     = dado_recebido[3:0];
    assign db_estado  = state;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INICIAL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, shadow-digit capture and pulse generation.
    always_comb begin
        state_next   = state;
        sh_ang_next  = sh_ang;
        sh_dist_next = sh_dist;
        pronto_next  = 1'b0;
        erro_next    = 1'b0;

        if (!ligar) begin
            state_next = INICIAL;
        end else if (pronto_rx) begin
            // Default for any wrong character in states 0-7: a stray '#'
            // already terminates the frame, anything else needs resync.
            state_next = is_hash ? INICIAL : DESCARTA;
            erro_next  = (state != DESCARTA);
            unique case (state)
                INICIAL: if (is_digit) begin
                    sh_ang_next[11:8] = digito;
                    state_next = ANG_DEZ;
                    erro_next  = 1'b0;
                end
                ANG_DEZ: if (is_digit) begin
                    sh_ang_next[7:4] = digito;
                    state_next = ANG_UNI;
                    erro_next  = 1'b0;
                end
                ANG_UNI: if (is_digit) begin
                    sh_ang_next[3:0] = digito;
                    state_next = ESPERA_VIRGULA;
                    erro_next  = 1'b0;
                end
                ESPERA_VIRGULA: if (is_virgula) begin
                    state_next = MED_CEN;
                    erro_next  = 1'b0;
                end
                MED_CEN: if (is_digit) begin
                    sh_dist_next[11:8] = digito;
                    state_next = MED_DEZ;
                    erro_next  = 1'b0;
                end
                MED_DEZ: if (is_digit) begin
                    sh_dist_next[7:4] = digito;
                    state_next = MED_UNI;
                    erro_next  = 1'b0;
                end
                MED_UNI: if (is_digit) begin
                    sh_dist_next[3:0] = digito;
                    state_next = ESPERA_HASH;
                    erro_next  = 1'b0;
                end
                ESPERA_HASH: if (is_hash) begin
                    pronto_next = 1'b1;
                    state_next  = INICIAL;
                    erro_next   = 1'b0;
                end
                DESCARTA: begin
                    state_next = is_hash ? INICIAL : DESCARTA;
                end
                default: begin
                    state_next = INICIAL;
                    erro_next  = 1'b0;
                end
            endcase
        end
    end

    // Shadow digits of the frame being assembled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_ang  <= '0;
            sh_dist <= '0;
        end else begin
            sh_ang  <= sh_ang_next;
            sh_dist <= sh_dist_next;
        end
    end

    // Registered outputs: publish shadow digits only on a complete frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            angulo    <= '0;
            distancia <= '0;
            pronto    <= 1'b0;
            erro      <= 1'b0;
        end else begin
            pronto <= pronto_next;
            erro   <= erro_next;
            if (pronto_next) begin
                angulo    <= sh_ang;
                distancia <= sh_dist;
            end
        end
    end

endmodule

// File: tb/tb_sonar_rx_parser.sv
// tb_sonar_rx_parser
// Scoreboard bench: the stimulus side runs a character-level frame model and
// queues the expected pronto/erro events; a monitor pops and compares them
// whenever the DUT pulses an output.
module tb_sonar_rx_parser;

    logic        clock;
    logic        reset;
    logic        ligar;
    logic [6:0]  dado_recebido;
    logic        pronto_rx;
    logic [11:0] angulo;
    logic [11:0] distancia;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    sonar_rx_parser #(.DATA_BITS(7)) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .dado_recebido (dado_recebido),
        .pronto_rx     (pronto_rx),
        .angulo        (angulo),
        .distancia     (distancia),
        .pronto        (pronto),
        .erro          (erro),
        .db_estado     (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          is_err;
        logic [11:0] a;
        logic [11:0] d;
        int          at_cyc;
    } ev_t;

    ev_t         sb[$];
    byte         fbuf[$];      // accepted characters of the current frame
    bit          discarding;
    logic [11:0] last_a, last_d;
    string       pattern = "DDD,DDD#";

    function automatic bit char_ok(int pos, byte c);
        byte p;
        p = pattern[pos];
        if (p == "D") return (c >= 8'h30 && c <= 8'h39);
        return c == p;
    endfunction

    function automatic logic [3:0] model_state();
        if (discarding) return 4'd8;
        return 4'(fbuf.size());
    endfunction

    task automatic m_reset_frame();
        fbuf.delete();
        discarding = 1'b0;
    endtask

    task automatic m_byte(input byte c, input int when);
        ev_t e;
        if (discarding) begin
            if (c == 8'h23) m_reset_frame();
            return;
        end
        if (char_ok(fbuf.size(), c)) begin
            if (fbuf.size() == 7) begin
                last_a = {fbuf[0][3:0], fbuf[1][3:0], fbuf[2][3:0]};
                last_d = {fbuf[4][3:0], fbuf[5][3:0], fbuf[6][3:0]};
                e = '{1'b0, last_a, last_d, when};
                sb.push_back(e);
                m_reset_frame();
            end else begin
                fbuf.push_back(c);
            end
        end else begin
            e = '{1'b1, last_a, last_d, when};
            sb.push_back(e);
            fbuf.delete();
            discarding = (c != 8'h23);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        ev_t e;
        if (!reset && (pronto || erro)) begin
            chk("pronto_erro_exclusive", {31'd0, pronto & erro}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, pronto, erro}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.at_cyc);
                chk("pulse_kind_erro", {31'd0, erro}, {31'd0, e.is_err});
                chk("angulo", {20'd0, angulo}, {20'd0, e.a});
                chk("distancia", {20'd0, distancia}, {20'd0, e.d});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_bytes(input byte q[$], input int gmin, input int gmax);
        int g;
        for (int i = 0; i < q.size(); i++) begin
            dado_recebido = q[i][6:0];
            pronto_rx = 1'b1;
            if (ligar) m_byte(q[i], cyc + 1);
            @(posedge clock);
            #1;
            chk("db_estado", {28'd0, db_estado}, {28'd0, model_state()});
            g = $urandom_range(gmax, gmin);
            if (g > 0) begin
                pronto_rx = 1'b0;
                repeat (g) @(posedge clock);
                #1;
            end
        end
        pronto_rx = 1'b0;
    endtask

    task automatic send_str(input string s, input int gap);
        byte q[$];
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        send_bytes(q, gap, gap);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        byte q[$];
        reset = 1'b1;
        ligar = 1'b1;
        pronto_rx = 1'b0;
        dado_recebido = '0;
        last_a = '0;
        last_d = '0;
        m_reset_frame();
        idle(3);
        chk("reset_angulo", {20'd0, angulo}, 32'd0);
        chk("reset_distancia", {20'd0, distancia}, 32'd0);
        chk("reset_pulses", {30'd0, pronto, erro}, 32'd0);
        chk("reset_state", {28'd0, db_estado}, 32'd0);
        reset = 1'b0;
        idle(2);

        // Nominal frame with wide gaps.
        send_str("090,125#", 10);
        // Bad digit, then recovery.
        send_str("09A,125#", 3);
        send_str("045,010#", 2);
        // Early terminator, then recovery.
        send_str("12#", 2);
        send_str("180,007#", 1);
        // Enable dropped mid-frame; bytes during disable are ignored.
        send_str("13", 1);
        ligar = 1'b0;
        m_reset_frame();
        send_str("#9,", 0);
        idle(1);
        ligar = 1'b1;
        send_str("020,300#", 1);
        // Asynchronous reset mid-frame.
        send_str("150,04", 1);
        #3;
        reset = 1'b1;
        #1;
        last_a = '0;
        last_d = '0;
        m_reset_frame();
        chk("async_reset_angulo", {20'd0, angulo}, 32'd0);
        chk("async_reset_distancia", {20'd0, distancia}, 32'd0);
        chk("async_reset_pulses", {30'd0, pronto, erro}, 32'd0);
        chk("async_reset_state", {28'd0, db_estado}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        send_str("001,002#", 1);
        // Back-to-back frames, pronto_rx high every cycle.
        send_str("010,020#030,040#", 0);
        idle(2);

        // Randomized frames: some corrupted, random gaps.
        for (int f = 0; f < 60; f++) begin
            q.delete();
            for (int i = 0; i < 8; i++) begin
                byte c;
                if (i == 3) c = 8'h2C;
                else if (i == 7) c = 8'h23;
                else c = byte'(8'h30 + $urandom_range(9, 0));
                q.push_back(c);
            end
            if ($urandom_range(3, 0) == 0) begin
                int p;
                p = $urandom_range(7, 0);
                q[p] = byte'($urandom_range(127, 0));
            end
            if ($urandom_range(7, 0) == 0) q = q[0:$urandom_range(6, 0)];
            send_bytes(q, 0, 3);
        end
        idle(4);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
